// File: rtl/gate_bist_sequencer.sv
// Exhaustive stimulus/response sequencer for a 2-input combinational gate.
// Walks (a,b) through 00..11 REPEAT times, checks y against the selected truth table and reports the result.
module gate_bist_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       func_sel,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_vec,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST   = 8'(REPEAT - 1);

  state_t           state_q;
  logic [2:0]       func_q;
  logic [1:0]       vec_q;
  logic [7:0]       pidx_q;
  logic [3:0]       settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_count_q;
  logic             ffv_q;
  logic [1:0]       ffvec_q;
  logic             cfg_err_q;

  logic             mismatch_d;
  logic [ERR_W-1:0] err_count_d;

  function automatic logic expected_y(input logic [2:0] f, input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    case (f)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~(a & b);
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      3'd5:    return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  // Comparison is only meaningful in SAMPLE; the latched function keeps mid-run func_sel edits out.
  always_comb begin
    mismatch_d  = (state_q == S_SAMPLE) && (dut_y != expected_y(func_q, vec_q));
    err_count_d = mismatch_d ? sat_inc(err_count_q) : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      func_q      <= 3'd0;
      vec_q       <= 2'd0;
      pidx_q      <= 8'd0;
      settle_q    <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      ffv_q       <= 1'b0;
      ffvec_q     <= 2'd0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (func_sel < 3'd6) begin
              func_q      <= func_sel;
              err_count_q <= '0;
              ffv_q       <= 1'b0;
              ffvec_q     <= 2'd0;
              pass_q      <= 1'b0;
              vec_q       <= 2'd0;
              pidx_q      <= 8'd0;
              settle_q    <= 4'd0;
              busy_q      <= 1'b1;
              state_q     <= S_DRIVE;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            vec_q   <= 2'd0;
          end else if (settle_q == SETTLE_LAST) begin
            settle_q <= 4'd0;
            state_q  <= S_SAMPLE;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        S_SAMPLE: begin
          // The sample in an abort cycle still counts toward the result.
          err_count_q <= err_count_d;
          if (mismatch_d && !ffv_q) begin
            ffv_q   <= 1'b1;
            ffvec_q <= vec_q;
          end
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            vec_q   <= 2'd0;
          end else if (vec_q != 2'b11) begin
            vec_q   <= vec_q + 2'd1;
            state_q <= S_DRIVE;
          end else if (pidx_q != PASS_LAST) begin
            vec_q   <= 2'd0;
            pidx_q  <= pidx_q + 8'd1;
            state_q <= S_DRIVE;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_count_d == '0);
          end
        end
        S_DONE: begin
          vec_q   <= 2'd0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dut_a            = vec_q[1];
  assign dut_b            = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Directed bench for gate_bist_sequencer: three instances with different parameter sets,
// a table of full runs plus hand sequences for cfg_err, abort and mid-run reset.
module tb_gate_bist_sequencer;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_NAND = 2;
  localparam int G_NOR  = 3;
  localparam int G_XOR  = 4;
  localparam int G_XNOR = 5;
  localparam int G_ONE  = 6;

  logic       clk;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [2:0] func_v [3];
  logic [2:0] dut_a_v, dut_b_v, dut_y_v;
  logic [2:0] busy_v, done_v, pass_v, ffv_v, cfg_v;
  logic [1:0] ffvec_v [3];
  logic [3:0] err0, err1;
  logic [1:0] err2;
  int         gmode [3];

  int n_cmp;
  int n_fail;

  function automatic logic tb_gate(input int m, input logic a, input logic b);
    case (m)
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_NAND:  return ~(a & b);
      G_NOR:   return ~(a | b);
      G_XOR:   return a ^ b;
      G_XNOR:  return ~(a ^ b);
      default: return 1'b1;
    endcase
  endfunction

  assign dut_y_v[0] = tb_gate(gmode[0], dut_a_v[0], dut_b_v[0]);
  assign dut_y_v[1] = tb_gate(gmode[1], dut_a_v[1], dut_b_v[1]);
  assign dut_y_v[2] = tb_gate(gmode[2], dut_a_v[2], dut_b_v[2]);

  gate_bist_sequencer #(.SETTLE_CYCLES(1), .REPEAT(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .func_sel(func_v[0]),
    .dut_a(dut_a_v[0]), .dut_b(dut_b_v[0]), .dut_y(dut_y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
    .first_fail_valid(ffv_v[0]), .first_fail_vec(ffvec_v[0]), .cfg_err(cfg_v[0])
  );

  gate_bist_sequencer #(.SETTLE_CYCLES(2), .REPEAT(3), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .func_sel(func_v[1]),
    .dut_a(dut_a_v[1]), .dut_b(dut_b_v[1]), .dut_y(dut_y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
    .first_fail_valid(ffv_v[1]), .first_fail_vec(ffvec_v[1]), .cfg_err(cfg_v[1])
  );

  gate_bist_sequencer #(.SETTLE_CYCLES(1), .REPEAT(2), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .func_sel(func_v[2]),
    .dut_a(dut_a_v[2]), .dut_b(dut_b_v[2]), .dut_y(dut_y_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2),
    .first_fail_valid(ffv_v[2]), .first_fail_vec(ffvec_v[2]), .cfg_err(cfg_v[2])
  );

  always #5 clk = ~clk;

  function automatic int err_of(input int i);
    case (i)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  function automatic int settle_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full run from IDLE; must be entered just after a negedge. Also retries start and
  // changes func_sel mid-run, which must have no effect.
  task automatic run_case(input int inst, input logic [2:0] f, input int gm, input int exp_lat,
                          input int exp_err, input logic exp_ffv, input logic [1:0] exp_ffvec,
                          input logic exp_pass, input string nm);
    int   lat;
    int   s;
    logic steps_ok;
    s            = settle_of(inst);
    gmode[inst]  = gm;
    func_v[inst] = f;
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1 start_v[inst] = 1'b0;
    lat      = -1;
    steps_ok = 1'b1;
    for (int w = 0; w < 80 && lat < 0; w++) begin
      @(negedge clk);
      if (w == 2) begin
        func_v[inst]  = f ^ 3'd1;
        start_v[inst] = 1'b1;
      end
      if (w == 3) start_v[inst] = 1'b0;
      if (done_v[inst]) lat = w;
      else if (!busy_v[inst] ||
               {dut_a_v[inst], dut_b_v[inst]} != 2'((w / (s + 1)) % 4)) steps_ok = 1'b0;
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_steps"}, 32'(steps_ok), 32'd1);
    check({nm, "_busy_at_done"}, 32'(busy_v[inst]), 32'd0);
    check({nm, "_err_count"}, err_of(inst), exp_err);
    check({nm, "_ffv"}, 32'(ffv_v[inst]), 32'(exp_ffv));
    check({nm, "_ffvec"}, 32'(ffvec_v[inst]), 32'(exp_ffvec));
    check({nm, "_pass"}, 32'(pass_v[inst]), 32'(exp_pass));
    @(negedge clk);
    check({nm, "_after_done"}, {28'd0, done_v[inst], busy_v[inst], dut_a_v[inst], dut_b_v[inst]}, 32'd0);
  endtask

  // Instance 0, AND expected, y tied high: mismatches at 00, 01, 10. Abort raised in window aw.
  task automatic abort_run(input int aw, input int exp_err, input string nm);
    int dones;
    gmode[0]   = G_ONE;
    func_v[0]  = 3'd0;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    for (int w = 0; w <= aw; w++) @(negedge clk);
    check({nm, "_vec_at_abort"}, {30'd0, dut_a_v[0], dut_b_v[0]}, 32'd2);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    check({nm, "_busy_done_pass"}, {29'd0, busy_v[0], done_v[0], pass_v[0]}, 32'd0);
    check({nm, "_err_kept"}, err_of(0), exp_err);
    check({nm, "_ff_kept"}, {29'd0, ffv_v[0], ffvec_v[0]}, 32'b100);
    dones = 0;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      if (done_v[0]) dones++;
    end
    check({nm, "_no_done"}, dones, 0);
  endtask

  typedef struct {
    int         inst;
    logic [2:0] f;
    int         gm;
    int         lat;
    int         err;
    logic       ffv;
    logic [1:0] ffvec;
    logic       pass;
  } rec_t;

  rec_t tbl [8];

  initial begin
    int dones;
    n_cmp  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    start_v = 3'b0;
    abort_v = 3'b0;
    for (int i = 0; i < 3; i++) begin
      func_v[i] = 3'd0;
      gmode[i]  = G_AND;
    end

    tbl[0] = '{0, 3'd0, G_AND,  8, 0, 1'b0, 2'b00, 1'b1};
    tbl[1] = '{0, 3'd0, G_ONE,  8, 3, 1'b1, 2'b00, 1'b0};
    tbl[2] = '{1, 3'd0, G_OR,  36, 6, 1'b1, 2'b01, 1'b0};
    tbl[3] = '{2, 3'd0, G_NAND,16, 3, 1'b1, 2'b00, 1'b0};
    tbl[4] = '{0, 3'd5, G_AND,  8, 1, 1'b1, 2'b00, 1'b0};
    tbl[5] = '{0, 3'd2, G_NOR,  8, 2, 1'b1, 2'b01, 1'b0};
    tbl[6] = '{0, 3'd3, G_NOR,  8, 0, 1'b0, 2'b00, 1'b1};
    tbl[7] = '{0, 3'd1, G_XOR,  8, 1, 1'b1, 2'b11, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_inst0", {dut_a_v[0], dut_b_v[0], busy_v[0], done_v[0], pass_v[0], err0, ffv_v[0], ffvec_v[0], cfg_v[0]}, 32'd0);
    check("reset_inst1", {dut_a_v[1], dut_b_v[1], busy_v[1], done_v[1], pass_v[1], err1, ffv_v[1], ffvec_v[1], cfg_v[1]}, 32'd0);
    check("reset_inst2", {dut_a_v[2], dut_b_v[2], busy_v[2], done_v[2], pass_v[2], err2, ffv_v[2], ffvec_v[2], cfg_v[2]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_case(tbl[i].inst, tbl[i].f, tbl[i].gm, tbl[i].lat, tbl[i].err, tbl[i].ffv,
               tbl[i].ffvec, tbl[i].pass, $sformatf("case%0d", i));

    // Illegal func_sel: one cfg_err pulse, no run, previous results (err 1, first fail 11) untouched.
    for (int f = 6; f < 8; f++) begin
      func_v[0]  = 3'(f);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1 start_v[0] = 1'b0;
      @(negedge clk);
      check($sformatf("cfg%0d_pulse", f), {30'd0, cfg_v[0], busy_v[0]}, 32'b10);
      check($sformatf("cfg%0d_results", f), {27'd0, pass_v[0], err0[1:0], ffv_v[0], ffvec_v[0]}, 32'b0_01_1_11);
      @(negedge clk);
      check($sformatf("cfg%0d_clear", f), {30'd0, cfg_v[0], busy_v[0]}, 32'd0);
    end
    run_case(0, 3'd4, G_XOR, 8, 0, 1'b0, 2'b00, 1'b1, "xor_ok");

    abort_run(4, 2, "abort_drive");
    abort_run(5, 3, "abort_sample");

    // start and abort together in IDLE: start wins. Then reset mid-run.
    gmode[0]   = G_ONE;
    func_v[0]  = 3'd0;
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    @(negedge clk);
    check("start_beats_abort", 32'(busy_v[0]), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset", {dut_a_v[0], dut_b_v[0], busy_v[0], done_v[0], pass_v[0], err0, ffv_v[0], ffvec_v[0], cfg_v[0]}, 32'd0);
    rst = 1'b0;
    dones = 0;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) dones++;
    end
    check("midrun_reset_idle", dones, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
